// File: rtl/mem_ctrl_pkg.sv
// Shared types for the unified memory controller: access size codes, FSM
// states and the size-to-byte-count helper.
package mem_ctrl_pkg;

  localparam int unsigned SIZE_W      = 2;
  localparam int unsigned MEM_CTRL_BUS_W = 32;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StXfer = 2'b01,
    StWait = 2'b10,
    StDone = 2'b11
  } state_e;

  // Bytes moved by one access; the unused encoding behaves as a word.
  function automatic int unsigned size_bytes(input logic [SIZE_W-1:0] size);
    int unsigned n;
    case (size)
      SizeByte: n = 1;
      SizeHalf: n = 2;
      default:  n = 4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Fixed-priority arbiter: lowest index wins, one-hot grant.
module mem_ctrl_arb #(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant_c
);

  always_comb begin
    logic found;
    found   = 1'b0;
    grant_c = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (req[i] && !found) begin
        grant_c[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Unified memory controller: arbitrates requesters onto one narrow RAM port,
// splits each access into beats and assembles reads little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_W     = 8,
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic [NUM_PORTS-1:0]          we_i,
  input  logic [SIZE_W*NUM_PORTS-1:0]   size_i,
  input  logic [ADDR_W*NUM_PORTS-1:0]   addr_i,
  input  logic [DATA_W*NUM_PORTS-1:0]   wdata_i,
  input  logic [NUM_PORTS-1:0]          flush_i,
  output logic [NUM_PORTS-1:0]          ready_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic [NUM_PORTS-1:0]          busy_o,
  output logic [ADDR_W-1:0]             ram_addr_o,
  output logic [MEM_W-1:0]              ram_dout_o,
  output logic [MEM_W/8-1:0]            ram_be_o,
  output logic                          ram_wr_o,
  input  logic [MEM_W-1:0]              ram_din_i
);

  localparam int unsigned BPB    = MEM_W / 8;
  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W  = $clog2(DATA_W / 8 + 1);
  localparam int unsigned WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e               state_q;
  logic [PORT_W-1:0]    port_q;
  logic                 we_q;
  logic [SIZE_W-1:0]    size_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [CNT_W-1:0]     beats_q;
  logic [CNT_W-1:0]     beat_q;
  logic [CNT_W-1:0]     cap_q;
  logic [WAIT_W-1:0]    wait_q;
  logic [RD_LAT-1:0]    rd_pipe_q;
  logic [DATA_W-1:0]    asm_q;

  logic [NUM_PORTS-1:0] grant_c;
  logic [PORT_W-1:0]    gnt_idx_c;
  logic                 gnt_any_c;

  logic                 src_we_c;
  logic [SIZE_W-1:0]    src_size_c;
  logic [ADDR_W-1:0]    src_addr_c;
  logic [DATA_W-1:0]    src_wdata_c;
  int                   beat_idx_c;
  int                   beat_lane_off_c;
  int                   beat_nbytes_c;
  int                   beat_rel_c;
  logic [ADDR_W-1:0]    beat_addr_c;
  logic [MEM_W/8-1:0]   beat_be_c;
  logic [MEM_W-1:0]     beat_dout_c;

  logic [RD_LAT-1:0]    rd_pipe_c;
  int                   cap_lane_off_c;
  int                   cap_nbytes_c;
  int                   cap_rel_c;
  logic [DATA_W-1:0]    asm_next_c;

  function automatic int unsigned beats_for(input logic [SIZE_W-1:0] size);
    int unsigned n;
    n = size_bytes(size) / BPB;
    return (n == 0) ? 1 : n;
  endfunction

  mem_ctrl_arb #(
    .NUM_PORTS(NUM_PORTS)
  ) u_arb (
    .req     (req_i & ~flush_i),
    .grant_c (grant_c)
  );

  assign busy_o = req_i & ~ready_o;

  always_comb begin
    gnt_idx_c = '0;
    gnt_any_c = |grant_c;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (grant_c[i]) gnt_idx_c = PORT_W'(i);
    end
  end

  // Beat source: the granted port while idle, otherwise the latched request.
  always_comb begin
    src_we_c    = we_q;
    src_size_c  = size_q;
    src_addr_c  = addr_q;
    src_wdata_c = wdata_q;
    beat_idx_c  = int'(beat_q) + 1;
    if (state_q == StIdle) begin
      src_we_c    = we_i[gnt_idx_c];
      src_size_c  = size_i[SIZE_W*int'(gnt_idx_c) +: SIZE_W];
      src_addr_c  = addr_i[ADDR_W*int'(gnt_idx_c) +: ADDR_W];
      src_wdata_c = wdata_i[DATA_W*int'(gnt_idx_c) +: DATA_W];
      beat_idx_c  = 0;
    end
  end

  // Next beat: aligned address, requested lanes only, lane-aligned write bytes.
  always_comb begin
    beat_lane_off_c = int'(src_addr_c[1:0]) & (int'(BPB) - 1);
    beat_nbytes_c   = int'(size_bytes(src_size_c));
    beat_rel_c      = 0;
    beat_be_c       = '0;
    beat_dout_c     = '0;
    beat_addr_c     = (src_addr_c & ~ADDR_W'(BPB - 1)) + ADDR_W'(beat_idx_c * int'(BPB));
    for (int j = 0; j < int'(BPB); j++) begin
      beat_rel_c = beat_idx_c * int'(BPB) + j - beat_lane_off_c;
      if (j >= beat_lane_off_c && beat_rel_c < beat_nbytes_c) begin
        beat_be_c[j]            = 1'b1;
        beat_dout_c[8*j +: 8]   = src_wdata_c[8*beat_rel_c +: 8];
      end
    end
  end

  // Tracks which cycles carry returning read data, RD_LAT after each read beat.
  always_comb begin
    rd_pipe_c    = '0;
    rd_pipe_c[0] = (state_q == StXfer) && !we_q;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      rd_pipe_c[i] = rd_pipe_q[i-1];
    end
  end

  always_comb begin
    asm_next_c     = asm_q;
    cap_lane_off_c = int'(addr_q[1:0]) & (int'(BPB) - 1);
    cap_nbytes_c   = int'(size_bytes(size_q));
    cap_rel_c      = 0;
    if (rd_pipe_q[RD_LAT-1]) begin
      for (int j = 0; j < int'(BPB); j++) begin
        cap_rel_c = int'(cap_q) * int'(BPB) + j - cap_lane_off_c;
        if (j >= cap_lane_off_c && cap_rel_c < cap_nbytes_c) begin
          asm_next_c[8*cap_rel_c +: 8] = ram_din_i[8*j +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      port_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      beats_q    <= '0;
      beat_q     <= '0;
      cap_q      <= '0;
      wait_q     <= '0;
      rd_pipe_q  <= '0;
      asm_q      <= '0;
      ready_o    <= '0;
      rdata_o    <= '0;
      ram_addr_o <= '0;
      ram_dout_o <= '0;
      ram_be_o   <= '0;
      ram_wr_o   <= 1'b0;
    end else begin
      ready_o   <= '0;
      rd_pipe_q <= rd_pipe_c;
      asm_q     <= asm_next_c;
      if (rd_pipe_q[RD_LAT-1]) cap_q <= cap_q + CNT_W'(1);

      case (state_q)
        StIdle: begin
          if (gnt_any_c) begin
            port_q     <= gnt_idx_c;
            we_q       <= src_we_c;
            size_q     <= src_size_c;
            addr_q     <= src_addr_c;
            wdata_q    <= src_wdata_c;
            beats_q    <= CNT_W'(beats_for(src_size_c));
            beat_q     <= '0;
            cap_q      <= '0;
            asm_q      <= '0;
            ram_addr_o <= beat_addr_c;
            ram_be_o   <= beat_be_c;
            ram_dout_o <= beat_dout_c;
            ram_wr_o   <= src_we_c;
            state_q    <= StXfer;
          end
        end

        StXfer: begin
          if (!we_q && flush_i[port_q]) begin
            ram_be_o  <= '0;
            ram_wr_o  <= 1'b0;
            rd_pipe_q <= '0;
            state_q   <= StIdle;
          end else if (beat_q == beats_q - CNT_W'(1)) begin
            ram_be_o <= '0;
            ram_wr_o <= 1'b0;
            wait_q   <= '0;
            if (we_q) begin
              ready_o[port_q] <= 1'b1;
              state_q         <= StDone;
            end else begin
              state_q <= StWait;
            end
          end else begin
            beat_q     <= beat_q + CNT_W'(1);
            ram_addr_o <= beat_addr_c;
            ram_be_o   <= beat_be_c;
            ram_dout_o <= beat_dout_c;
            ram_wr_o   <= we_q;
          end
        end

        StWait: begin
          if (flush_i[port_q]) begin
            rd_pipe_q <= '0;
            state_q   <= StIdle;
          end else if (wait_q == WAIT_W'(RD_LAT - 1)) begin
            rdata_o         <= asm_next_c;
            ready_o[port_q] <= 1'b1;
            state_q         <= StDone;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end

        StDone: state_q <= StIdle;

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte-wide and a word-wide RAM instance,
// expected beats and completions queued at issue, checked by a monitor.
module tb_mem_ctrl;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_mem = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: byte-wide RAM
  logic [1:0]  req8 = '0, we8 = '0, flush8 = '0, rdy8, busy8;
  logic [3:0]  size8 = '0;
  logic [63:0] addr8 = '0, wdata8 = '0;
  logic [31:0] rdata8, ram_addr8;
  logic [7:0]  ram_dout8, din8;
  logic [0:0]  ram_be8;
  logic        ram_wr8;

  // Instance 1: word-wide RAM
  logic [1:0]  req32 = '0, we32 = '0, flush32 = '0, rdy32, busy32;
  logic [3:0]  size32 = '0;
  logic [63:0] addr32 = '0, wdata32 = '0;
  logic [31:0] rdata32, ram_addr32, ram_dout32, din32;
  logic [3:0]  ram_be32;
  logic        ram_wr32;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_W(8), .NUM_PORTS(2), .RD_LAT(1)) dut8 (
    .clk(clk), .rst(rst), .req_i(req8), .we_i(we8), .size_i(size8), .addr_i(addr8),
    .wdata_i(wdata8), .flush_i(flush8), .ready_o(rdy8), .rdata_o(rdata8), .busy_o(busy8),
    .ram_addr_o(ram_addr8), .ram_dout_o(ram_dout8), .ram_be_o(ram_be8), .ram_wr_o(ram_wr8),
    .ram_din_i(din8));

  mem_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_W(32), .NUM_PORTS(2), .RD_LAT(1)) dut32 (
    .clk(clk), .rst(rst), .req_i(req32), .we_i(we32), .size_i(size32), .addr_i(addr32),
    .wdata_i(wdata32), .flush_i(flush32), .ready_o(rdy32), .rdata_o(rdata32), .busy_o(busy32),
    .ram_addr_o(ram_addr32), .ram_dout_o(ram_dout32), .ram_be_o(ram_be32), .ram_wr_o(ram_wr32),
    .ram_din_i(din32));

  // RAM models with one cycle of read latency
  logic [7:0] mem8  [0:1023];
  logic [7:0] mem32 [0:1023];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) begin
        mem8[i]  <= 8'h00;
        mem32[i] <= 8'h00;
      end
      mem8[10'h100] <= 8'h11; mem8[10'h101] <= 8'h22;
      mem8[10'h102] <= 8'h33; mem8[10'h103] <= 8'h44;
      mem8[10'h202] <= 8'h77; mem8[10'h223] <= 8'h99;
      mem32[10'h100] <= 8'h11; mem32[10'h101] <= 8'h22;
      mem32[10'h102] <= 8'h33; mem32[10'h103] <= 8'h44;
    end else begin
      if (ram_wr8 && ram_be8[0]) mem8[ram_addr8[9:0]] <= ram_dout8;
      for (int j = 0; j < 4; j++) begin
        if (ram_wr32 && ram_be32[j]) mem32[{ram_addr32[9:2], 2'(j)}] <= ram_dout32[8*j +: 8];
      end
    end
    din8 <= mem8[ram_addr8[9:0]];
    for (int j = 0; j < 4; j++) din32[8*j +: 8] <= mem32[{ram_addr32[9:2], 2'(j)}];
  end

  typedef struct {
    int          inst;
    int          port;
    bit          rd;
    logic [31:0] data;
    int          cy;
  } rsp_t;

  typedef struct {
    int          inst;
    logic [31:0] addr;
    logic [3:0]  be;
    bit          wr;
    logic [31:0] dout;
    int          cy;
  } beat_t;

  rsp_t  rsp_q[$];
  beat_t exp_beats[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void exp_rsp(input int inst, input int p, input bit rd,
                                  input logic [31:0] d, input int cy);
    rsp_t r;
    r.inst = inst; r.port = p; r.rd = rd; r.data = d; r.cy = cy;
    rsp_q.push_back(r);
  endfunction

  function automatic void exp_beat(input int inst, input logic [31:0] a, input logic [3:0] be,
                                   input bit wr, input logic [31:0] d, input int cy);
    beat_t b;
    b.inst = inst; b.addr = a; b.be = be; b.wr = wr; b.dout = d; b.cy = cy;
    exp_beats.push_back(b);
  endfunction

  task automatic mon_inst(input int inst, input logic [1:0] rdy, input logic [31:0] rd,
                          input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] dout, input logic wr);
    rsp_t        r;
    beat_t       b;
    logic [31:0] mask;
    for (int p = 0; p < 2; p++) begin
      if (rdy[p]) begin
        if (rsp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ready: inst %0d port %0d pulsed at cycle %0d, required none", inst, p, cyc);
        end else begin
          r = rsp_q.pop_front();
          check("ready_inst", 32'(inst), 32'(r.inst));
          check("ready_port", 32'(p), 32'(r.port));
          check("ready_cycle", 32'(cyc), 32'(r.cy));
          if (r.rd) check("rdata", rd, r.data);
        end
      end
    end
    if (be != 4'b0000) begin
      if (exp_beats.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_beat: inst %0d addr %h at cycle %0d, required none", inst, addr, cyc);
      end else begin
        b = exp_beats.pop_front();
        mask = '0;
        for (int j = 0; j < 4; j++) if (b.be[j]) mask[8*j +: 8] = 8'hFF;
        check("beat_inst", 32'(inst), 32'(b.inst));
        check("beat_addr", addr, b.addr);
        check("beat_be", 32'(be), 32'(b.be));
        check("beat_wr", 32'(wr), 32'(b.wr));
        check("beat_cycle", 32'(cyc), 32'(b.cy));
        if (b.wr) check("beat_dout", dout & mask, b.dout & mask);
      end
    end
  endtask

  always @(negedge clk) begin
    mon_inst(0, rdy8, rdata8, ram_addr8, 4'(ram_be8), 32'(ram_dout8), ram_wr8);
    mon_inst(1, rdy32, rdata32, ram_addr32, ram_be32, ram_dout32, ram_wr32);
  end

  task automatic drive(input int inst, input int p, input bit we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    if (inst == 0) begin
      we8[p] = we; size8[2*p +: 2] = sz; addr8[32*p +: 32] = a; wdata8[32*p +: 32] = wd;
      req8[p] = 1'b1;
    end else begin
      we32[p] = we; size32[2*p +: 2] = sz; addr32[32*p +: 32] = a; wdata32[32*p +: 32] = wd;
      req32[p] = 1'b1;
    end
  endtask

  // Waits for this port's completion pulse, then drops its request.
  task automatic wait_ready(input int inst, input int p);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = (inst == 0) ? rdy8[p] : rdy32[p];
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL ready_timeout: inst %0d port %0d got no ready, required one within 40 cycles", inst, p);
    end
    if (inst == 0) req8[p] = 1'b0; else req32[p] = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic next_cycle(output int c);
    @(posedge clk);
    #1;
    c = cyc;
  endtask

  initial begin
    int c;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(rdy8), 32'h0);
    check("rst_be", 32'(ram_be8), 32'h0);
    check("rst_wr", 32'(ram_wr8), 32'h0);
    check("rst_addr", ram_addr8, 32'h0);
    check("rst_rdata", rdata8, 32'h0);
    check("rst_dout32", ram_dout32, 32'h0);
    init_mem = 1'b0;
    rst = 1'b0;

    // Word read on fetch port through a byte RAM
    next_cycle(c);
    drive(0, 1, 1'b0, SZ_W, 32'h100, 32'h0);
    for (int k = 0; k < 4; k++) exp_beat(0, 32'h100 + 32'(k), 4'b0001, 1'b0, 32'h0, c + 1 + k);
    exp_rsp(0, 1, 1'b1, 32'h44332211, c + 6);
    wait_ready(0, 1);

    // Half write on data port
    next_cycle(c);
    drive(0, 0, 1'b1, SZ_H, 32'h200, 32'hAABBCCDD);
    exp_beat(0, 32'h200, 4'b0001, 1'b1, 32'hDD, c + 1);
    exp_beat(0, 32'h201, 4'b0001, 1'b1, 32'hCC, c + 2);
    exp_rsp(0, 0, 1'b0, 32'h0, c + 3);
    wait_ready(0, 0);
    check("mem_200", 32'(mem8[10'h200]), 32'hDD);
    check("mem_201", 32'(mem8[10'h201]), 32'hCC);
    check("mem_202_kept", 32'(mem8[10'h202]), 32'h77);

    // Both ports in the same cycle: port 0 first, port 1 waits one idle cycle
    next_cycle(c);
    drive(0, 0, 1'b1, SZ_H, 32'h300, 32'h12345678);
    drive(0, 1, 1'b0, SZ_W, 32'h100, 32'h0);
    exp_beat(0, 32'h300, 4'b0001, 1'b1, 32'h78, c + 1);
    exp_beat(0, 32'h301, 4'b0001, 1'b1, 32'h56, c + 2);
    exp_rsp(0, 0, 1'b0, 32'h0, c + 3);
    for (int k = 0; k < 4; k++) exp_beat(0, 32'h100 + 32'(k), 4'b0001, 1'b0, 32'h0, c + 5 + k);
    exp_rsp(0, 1, 1'b1, 32'h44332211, c + 10);
    fork
      wait_ready(0, 0);
      wait_ready(0, 1);
      begin
        wait_cyc(c + 1);
        check("busy1_waiting", 32'(busy8[1]), 32'h1);
        wait_cyc(c + 3);
        check("busy1_at_ready0", 32'(busy8[1]), 32'h1);
        check("busy0_at_ready0", 32'(busy8[0]), 32'h0);
      end
    join
    check("mem_301", 32'(mem8[10'h301]), 32'h56);

    // Flush a fetch read during its second beat
    next_cycle(c);
    drive(0, 1, 1'b0, SZ_W, 32'h100, 32'h0);
    exp_beat(0, 32'h100, 4'b0001, 1'b0, 32'h0, c + 1);
    exp_beat(0, 32'h101, 4'b0001, 1'b0, 32'h0, c + 2);
    wait_cyc(c + 1);
    @(posedge clk); #1;
    flush8[1] = 1'b1;
    @(posedge clk); #1;
    flush8[1] = 1'b0;
    req8[1] = 1'b0;
    wait_cyc(c + 3);
    check("flush_be_stopped", 32'(ram_be8), 32'h0);
    wait_cyc(c + 8);

    // Flush on a write is ignored
    next_cycle(c);
    drive(0, 0, 1'b1, SZ_W, 32'h210, 32'h01020304);
    exp_beat(0, 32'h210, 4'b0001, 1'b1, 32'h04, c + 1);
    exp_beat(0, 32'h211, 4'b0001, 1'b1, 32'h03, c + 2);
    exp_beat(0, 32'h212, 4'b0001, 1'b1, 32'h02, c + 3);
    exp_beat(0, 32'h213, 4'b0001, 1'b1, 32'h01, c + 4);
    exp_rsp(0, 0, 1'b0, 32'h0, c + 5);
    wait_cyc(c + 1);
    @(posedge clk); #1;
    flush8[0] = 1'b1;
    wait_ready(0, 0);
    flush8[0] = 1'b0;
    check("mem_213", 32'(mem8[10'h213]), 32'h01);

    // Reset during the third beat of a word write
    next_cycle(c);
    drive(0, 0, 1'b1, SZ_W, 32'h220, 32'hCAFEF00D);
    exp_beat(0, 32'h220, 4'b0001, 1'b1, 32'h0D, c + 1);
    exp_beat(0, 32'h221, 4'b0001, 1'b1, 32'hF0, c + 2);
    exp_beat(0, 32'h222, 4'b0001, 1'b1, 32'hFE, c + 3);
    wait_cyc(c + 2);
    @(posedge clk); #1;
    rst = 1'b1;
    req8[0] = 1'b0;
    wait_cyc(c + 4);
    check("rst_mid_wr", 32'(ram_wr8), 32'h0);
    check("rst_mid_be", 32'(ram_be8), 32'h0);
    check("rst_mid_addr", ram_addr8, 32'h0);
    check("rst_mid_dout", 32'(ram_dout8), 32'h0);
    check("rst_mid_rdata", rdata8, 32'h0);
    check("rst_mid_ready", 32'(rdy8), 32'h0);
    rst = 1'b0;
    check("mem_222_partial", 32'(mem8[10'h222]), 32'hFE);
    check("mem_223_kept", 32'(mem8[10'h223]), 32'h99);

    // New request accepted after reset
    next_cycle(c);
    drive(0, 1, 1'b0, SZ_H, 32'h102, 32'h0);
    exp_beat(0, 32'h102, 4'b0001, 1'b0, 32'h0, c + 1);
    exp_beat(0, 32'h103, 4'b0001, 1'b0, 32'h0, c + 2);
    exp_rsp(0, 1, 1'b1, 32'h00004433, c + 4);
    wait_ready(0, 1);

    // Word-wide RAM: byte write into the top lane, then a half read across lanes
    next_cycle(c);
    drive(1, 0, 1'b1, SZ_B, 32'h103, 32'h0000005A);
    exp_beat(1, 32'h100, 4'b1000, 1'b1, 32'h5A000000, c + 1);
    exp_rsp(1, 0, 1'b0, 32'h0, c + 2);
    wait_ready(1, 0);
    check("mem32_103", 32'(mem32[10'h103]), 32'h5A);
    check("mem32_102_kept", 32'(mem32[10'h102]), 32'h33);

    next_cycle(c);
    drive(1, 0, 1'b0, SZ_H, 32'h102, 32'h0);
    exp_beat(1, 32'h100, 4'b1100, 1'b0, 32'h0, c + 1);
    exp_rsp(1, 0, 1'b1, 32'h00005A33, c + 3);
    wait_ready(1, 0);

    repeat (4) @(negedge clk);
    check("pending_rsp", 32'(rsp_q.size()), 32'h0);
    check("pending_beats", 32'(exp_beats.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
